// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: control encodings shared by the main FSM and the ALU/instruction decoders
package main_fsm_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
    } statetype;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/main_fsm.sv
// main_fsm: multicycle Moore control FSM; MAIN_FSM_MEMWAIT_EN adds MemReady wait states
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
`ifdef MAIN_FSM_MEMWAIT_EN
    input  logic       MemReady,
`endif
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] state_o
);
    statetype state, next;
    logic ready;
`ifdef MAIN_FSM_MEMWAIT_EN
    assign ready = MemReady;
`else
    assign ready = 1'b1;
`endif
    assign state_o = state;
    // state register; reset always lands in FETCH
    always_ff @(posedge clk)
        state <= reset ? FETCH : next;
    // next state; memory-facing states hold until ready, unknown encodings recover to FETCH
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = ready ? DECODE : FETCH;
            DECODE:   next = (op == OP_LOAD || op == OP_STORE) ? MEMADR :
                             (op == OP_RTYPE)  ? EXECUTER :
                             (op == OP_ITYPE)  ? EXECUTEI :
                             (op == OP_BRANCH) ? BEQ :
                             (op == OP_JAL)    ? JAL : FETCH;
            MEMADR:   next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  next = ready ? MEMWB : MEMREAD;
            MEMWRITE: next = ready ? FETCH : MEMWRITE;
            EXECUTER, EXECUTEI, JAL: next = ALUWB;
            default:  next = FETCH;
        endcase
    end
    // Moore outputs decoded from the state register only
    always_comb begin
        ALUOp     = ALUOP_ADD;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCUpdate  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB:    RegWrite = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = ALUOP_SUB;
                Branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: random and directed instruction streams checked against a per-opcode state-trace model
module tb_main_fsm;
    import main_fsm_pkg::*;
`ifdef MAIN_FSM_MEMWAIT_EN
    localparam bit MEMWAIT = 1'b1;
    logic MemReady = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
    logic [3:0] state_o;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    always #5 clk = ~clk;
    main_fsm dut (
        .clk(clk), .reset(reset), .op(op),
`ifdef MAIN_FSM_MEMWAIT_EN
        .MemReady(MemReady),
`endif
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .state_o(state_o)
    );
    wire [13:0] obs = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite};
    // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite}
    function automatic logic [13:0] exp_out(input int s);
        case (s)
            0:  return {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            1:  return {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            2:  return {2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            3:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            4:  return {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            5:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            6:  return {2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            7:  return {2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            8:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            9:  return {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            10: return {2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            default: return 14'd0;
        endcase
    endfunction
    // whole-instruction state trace for an opcode, as listed in the instruction table
    task automatic load_seq(input logic [6:0] o);
        if (o == 7'b0000011) exp_q = {0, 1, 2, 3, 4};
        else if (o == 7'b0100011) exp_q = {0, 1, 2, 5};
        else if (o == 7'b0110011) exp_q = {0, 1, 6, 8};
        else if (o == 7'b0010011) exp_q = {0, 1, 7, 8};
        else if (o == 7'b1100011) exp_q = {0, 1, 9};
        else if (o == 7'b1101111) exp_q = {0, 1, 10, 8};
        else exp_q = {0, 1};
    endtask
    function automatic int reg_writes(input logic [6:0] o);
        return (o == 7'b0000011 || o == 7'b0110011 || o == 7'b0010011 || o == 7'b1101111) ? 1 : 0;
    endfunction
    // stall < 0: random stalls on memory-facing states; stall >= 0: that many stalls in MEMWRITE only
    task automatic run_instr(input logic [6:0] o, input int stall);
        int rw, mw, exp_mw, n;
        op = o;
        load_seq(o);
        rw = 0;
        mw = 0;
        exp_mw = 0;
        foreach (exp_q[i]) begin
            n = 0;
            if (MEMWAIT && exp_q[i] inside {0, 3, 5})
                n = (stall < 0) ? int'($urandom_range(0, 3)) : ((exp_q[i] == 5) ? stall : 0);
            if (exp_q[i] == 5) exp_mw = n + 1;
            for (int k = 0; k <= n; k++) begin
                n_cmp++;
                if (state_o !== 4'(exp_q[i])) begin
                    n_bad++;
                    $display("FAIL state op=%b step=%0d got=%0d exp=%0d", o, i, state_o, exp_q[i]);
                end
                n_cmp++;
                if (obs !== exp_out(exp_q[i])) begin
                    n_bad++;
                    $display("FAIL outputs op=%b state=%0d got=%b exp=%b", o, exp_q[i], obs, exp_out(exp_q[i]));
                end
                rw += int'(RegWrite);
                mw += int'(MemWrite);
`ifdef MAIN_FSM_MEMWAIT_EN
                MemReady = (k == n);
`endif
                @(negedge clk);
            end
        end
`ifdef MAIN_FSM_MEMWAIT_EN
        MemReady = 1'b1;
`endif
        n_cmp++;
        if (rw !== reg_writes(o)) begin
            n_bad++;
            $display("FAIL regwrite_count op=%b got=%0d exp=%0d", o, rw, reg_writes(o));
        end
        n_cmp++;
        if (mw !== exp_mw) begin
            n_bad++;
            $display("FAIL memwrite_count op=%b got=%0d exp=%0d", o, mw, exp_mw);
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        op = 7'b0110011;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (state_o !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_state got=%0d exp=0", state_o);
            end
            n_cmp++;
            if (obs !== exp_out(0)) begin
                n_bad++;
                $display("FAIL reset_outputs got=%b exp=%b", obs, exp_out(0));
            end
        end
        reset = 1'b0;
    endtask
    task automatic test_directed();
        run_instr(7'b0110011, 0);
        run_instr(7'b0000011, 0);
        run_instr(7'b0100011, 0);
        run_instr(7'b1100011, 0);
        run_instr(7'b1101111, 0);
        run_instr(7'b0010011, 0);
        run_instr(7'b1111111, 0);
    endtask
    task automatic test_reset_mid();
        op = 7'b0100011;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (state_o !== 4'd2) begin
            n_bad++;
            $display("FAIL mid_reset_setup got=%0d exp=2", state_o);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (state_o !== 4'd0) begin
            n_bad++;
            $display("FAIL mid_reset_state got=%0d exp=0", state_o);
        end
        n_cmp++;
        if (obs !== exp_out(0) || MemWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs got=%b exp=%b", obs, exp_out(0));
        end
        run_instr(7'b0100011, 0);
    endtask
    task automatic test_memwait();
        if (MEMWAIT) run_instr(7'b0100011, 3);
    endtask
    task automatic test_random();
        logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        for (int i = 0; i < 60; i++) begin
            int r = int'($urandom_range(0, 7));
            run_instr(r < 6 ? ops[r] : 7'($urandom), -1);
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_memwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
